sim_run_ctrl: RTL
=================

Name: sim_run_ctrl

Overview:
- Parametrised reset sequencer and run supervisor for the riscv_top simulation and FPGA flow.
- It replaces a fixed hold of raw reset followed by a free-running clock.
- Stretches the raw reset for a configurable number of cycles, then releases N reset domains in staggered order.
- Counts run cycles, ends the run on a halt request or on a watchdog timeout, gates a waveform-dump window, and supports restart without raw reset.

Parameters:
RST_CYCLES, 25, cycles reset is held after raw rst deasserts (>=1)
N_RST, 3, number of reset domains released in sequence (>=1)
RST_STAGGER, 2, cycles between successive domain releases (0 = release all together)
CNT_W, 32, width of cycle counter
TIMEOUT_CYCLES, 1000, run cycles before watchdog fires (0 = watchdog disabled)
DUMP_START, 0, first run cycle count with dump_en high
DUMP_END, 0, run cycle count at which dump_en drops (DUMP_END<=DUMP_START = dump never enabled)

Ports:
clk  input  1  system clock
rst  input  1  raw reset, asynchronous, active-high
halt_req  input  1  program-finished request, sampled in RUN only
restart  input  1  single-cycle pulse, honoured in DONE/TOUT only
sys_rst  output  N_RST  per-domain reset, active-high; bit 0 released first
run  output  1  high while in RUN
cycle_cnt  output  CNT_W  run cycle count
done  output  1  sticky: run ended by halt_req
timeout  output  1  sticky: run ended by watchdog
dump_en  output  1  waveform-dump window

Behaviour:
- Reset is asynchronous and active-high. Clock and reset ports are named clk and rst.
- While rst is high: state HOLD, internal counter 0, sys_rst all ones, run 0, cycle_cnt 0, done 0, timeout 0, dump_en 0.
- All outputs are registered. No combinational path runs from any input to any output.
- States are HOLD, STAGGER, RUN, DONE and TOUT.
- Edge numbering: edge k is the k-th rising clk edge with rst low.
- HOLD:
  - The counter increments each edge.
  - At edge RST_CYCLES, sys_rst[0] clears.
  - If N_RST=1 or RST_STAGGER=0, all bits clear at that edge and the state goes to RUN. Otherwise it goes to STAGGER.
- STAGGER:
  - sys_rst[i] clears at edge RST_CYCLES + i*RST_STAGGER.
  - At the edge the last bit clears, the state goes to RUN and run rises.
  - A cleared bit never re-asserts except via restart or rst.
- RUN:
  - cycle_cnt increments by 1 each edge, saturating at all ones. Its first increment is the edge after run rises.
  - If halt_req=1: go to DONE, set done=1, clear run, freeze cycle_cnt. The halting edge does not increment.
  - Else if TIMEOUT_CYCLES!=0 and cycle_cnt==TIMEOUT_CYCLES-1: go to TOUT, set timeout=1, clear run, freeze cycle_cnt.
  - If halt_req and the timeout condition occur on the same edge, halt wins.
- HOLD/STAGGER: halt_req and restart are ignored.
- dump_en: registered. It is high during RUN when DUMP_START <= cycle_cnt < DUMP_END, using the value of cycle_cnt after the update. It is 0 outside RUN.
- DONE/TOUT:
  - sys_rst stays released, so domains keep their final state for inspection.
  - cycle_cnt, done and timeout hold.
  - A restart pulse returns the state to HOLD, sets sys_rst to all ones, and clears the counter, cycle_cnt, done, timeout and dump_en. The HOLD period is then RST_CYCLES edges, counted from the edge after the restart edge.
- rst asserted mid-operation in any state aborts immediately (asynchronously) to the reset values.
- Width rule: comparisons are at CNT_W. TIMEOUT_CYCLES, DUMP_START and DUMP_END are truncated to CNT_W.

Test Plan:
- Defaults; rst high 50 ns, then low -> sys_rst=3'b111 through edge 24; sys_rst=3'b110 at edge 25, 3'b100 at edge 27, 3'b000 at edge 29; run=1 from edge 29.
- RST_STAGGER=0 -> sys_rst goes 3'b111 to 3'b000 at edge 25; run=1 at edge 25; STAGGER is never entered.
- Defaults; halt_req pulsed when cycle_cnt=40 -> done=1, run=0, cycle_cnt stays 40; later halt_req pulses are ignored.
- No halt -> timeout=1 at the edge where cycle_cnt would reach 1000, cycle_cnt frozen at 999; halt_req asserted on that same edge instead gives done=1, timeout=0.
- DUMP_START=10, DUMP_END=13 -> dump_en high for exactly 3 edges, while cycle_cnt is 10, 11, 12.
- In DONE, pulse restart -> sys_rst=3'b111, done=0, cycle_cnt=0, and the sequence repeats with identical timing. Pulsing restart during RUN has no effect, and asserting rst during STAGGER returns sys_rst to 3'b111 without waiting for a clock edge.

Source files
------------

// File: rtl/sim_run_ctrl.sv
// Reset sequencer and run supervisor: stretched reset, staggered domain release,
// run cycle counting with halt/watchdog termination, dump window and restart.
module sim_run_ctrl #(
  parameter int RST_CYCLES     = 25,
  parameter int N_RST          = 3,
  parameter int RST_STAGGER    = 2,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int DUMP_START     = 0,
  parameter int DUMP_END       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_req,
  input  logic             restart,
  output logic [N_RST-1:0] sys_rst,
  output logic             run,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             done,
  output logic             timeout,
  output logic             dump_en
);

  // state   | meaning
  // HOLD    | stretched reset, all domains held
  // STAGGER | releasing domains one by one
  // RUN     | program running, cycle_cnt counting
  // DONE    | ended by halt_req, waiting for restart
  // TOUT    | ended by watchdog, waiting for restart
  localparam logic [2:0] S_HOLD    = 3'd0;
  localparam logic [2:0] S_STAGGER = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_TOUT    = 3'd4;

  localparam int MAXC = (RST_CYCLES > RST_STAGGER) ? RST_CYCLES : RST_STAGGER;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0]    HOLD_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]    STG_LAST  = CW'((RST_STAGGER > 0) ? RST_STAGGER - 1 : 0);
  localparam bit               DIRECT    = (N_RST == 1) || (RST_STAGGER == 0);
  localparam logic [CNT_W-1:0] TO_C      = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_M1     = TO_C - CNT_W'(1);
  localparam bit               TO_EN     = (TO_C != '0);
  localparam logic [CNT_W-1:0] DS_C      = CNT_W'(DUMP_START);
  localparam logic [CNT_W-1:0] DE_C      = CNT_W'(DUMP_END);
  localparam bit               DUMP_ON   = (DE_C > DS_C);
  localparam logic [CNT_W-1:0] DUMP_LEN  = DE_C - DS_C;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [N_RST-1:0] rst_sh;
  logic [CNT_W-1:0] cnt_nx;
  logic             win_nx;
  logic             win_zero;

  // modular distance test avoids constant-compare corner cases when DUMP_START is 0
  always_comb begin
    rst_sh   = sys_rst << 1;
    cnt_nx   = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_W'(1);
    win_nx   = DUMP_ON && ((cnt_nx - DS_C) < DUMP_LEN);
    win_zero = DUMP_ON && (DS_C == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_HOLD;
      cnt       <= '0;
      sys_rst   <= '1;
      run       <= 1'b0;
      cycle_cnt <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      dump_en   <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt <= '0;
            if (DIRECT) begin
              sys_rst <= '0;
              state   <= S_RUN;
              run     <= 1'b1;
              dump_en <= win_zero;
            end else begin
              sys_rst <= rst_sh;
              state   <= S_STAGGER;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STAGGER: begin
          if (cnt == STG_LAST) begin
            cnt     <= '0;
            sys_rst <= rst_sh;
            if (rst_sh == '0) begin
              state   <= S_RUN;
              run     <= 1'b1;
              dump_en <= win_zero;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RUN: begin
          if (halt_req) begin
            state   <= S_DONE;
            done    <= 1'b1;
            run     <= 1'b0;
            dump_en <= 1'b0;
          end else if (TO_EN && (cycle_cnt == TO_M1)) begin
            state   <= S_TOUT;
            timeout <= 1'b1;
            run     <= 1'b0;
            dump_en <= 1'b0;
          end else begin
            cycle_cnt <= cnt_nx;
            dump_en   <= win_nx;
          end
        end
        S_DONE, S_TOUT: begin
          if (restart) begin
            state     <= S_HOLD;
            cnt       <= '0;
            sys_rst   <= '1;
            cycle_cnt <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            dump_en   <= 1'b0;
          end
        end
        default: state <= S_HOLD;
      endcase
    end
  end

endmodule
